edge_to_level: RTL and testbench

Edge-event decoder: reconstructs a level waveform from single-cycle edge pulses, such as those produced by a dual-edge detector. Each accepted edge pulse toggles `level_out`. A minimum hold time is enforced between toggles. One edge arriving during the hold window is deferred and applied when the window ends; further edges are discarded and flagged. The block sits downstream of edge detection and debouncing logic, and regenerates a clean, rate-limited level for the FSMD that consumes it.

---
 rtl/edge_to_level.sv | 80 ++++++++
 tb/tb_edge_to_level.sv | 131 +++++++++++++
 2 files changed

// File: rtl/edge_to_level.sv
// Rebuilds a level from single-cycle edge pulses. Each accepted edge toggles the level, and the
// level is then held for at least HOLD_CYCLES cycles. One edge may be deferred; any further edge is dropped.
module edge_to_level #(
    parameter int   HOLD_CYCLES = 4,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic edge_in,
    output logic level_out,
    output logic busy,
    output logic drop
);
    localparam int             CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, PEND = 2'd2} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          level_nx, drop_nx, toggle, term;

    // The hold window has expired. The next edge can toggle now.
    assign term = (state != IDLE) && (cnt == '0);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_out <= INIT_LEVEL;
            drop      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            level_out <= level_nx;
            drop      <= drop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        drop_nx  = 1'b0;
        toggle   = 1'b0;
        case (state)
            IDLE: begin
                if (edge_in) begin
                    toggle   = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (term) begin
                    if (edge_in) toggle = 1'b1;
                    else         state_nx = IDLE;
                end else if (edge_in) begin
                    state_nx = PEND;
                end
            end
            PEND: begin
                // On expiry, apply the deferred toggle. An edge that arrives in the same cycle becomes the new deferred edge.
                if (term) begin
                    toggle   = 1'b1;
                    state_nx = edge_in ? PEND : HOLD;
                end else if (edge_in) begin
                    drop_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        cnt_nx = cnt;
        if (toggle)
            cnt_nx = CNT_LOAD;
        else if ((state != IDLE) && (cnt != '0))
            cnt_nx = cnt - CW'(1);

        level_nx = level_out ^ toggle;
    end
endmodule

// File: tb/tb_edge_to_level.sv
// Scoreboard bench for edge_to_level. It instantiates HOLD_CYCLES=4 and HOLD_CYCLES=1 side by side.
// A time-based reference model pushes the expected outputs on every drive.
module tb_edge_to_level;
    logic clk = 1'b0, reset = 1'b1, e4 = 1'b0, e1 = 1'b0;
    logic l4, b4, d4, l1, b1, d1;

    edge_to_level #(.HOLD_CYCLES(4), .INIT_LEVEL(1'b0)) u4 (
        .clk(clk), .reset(reset), .edge_in(e4), .level_out(l4), .busy(b4), .drop(d4));
    edge_to_level #(.HOLD_CYCLES(1), .INIT_LEVEL(1'b0)) u1 (
        .clk(clk), .reset(reset), .edge_in(e1), .level_out(l1), .busy(b1), .drop(d1));

    always #5 clk = ~clk;

    typedef struct {
        bit lvl;
        bit busy;
        bit pend;
        bit drop;
        int last_t;
    } mdl_t;

    mdl_t       m4, m1;
    int         n = 0;
    int         errors = 0, checks = 0;
    logic [5:0] sb[$];
    int         sb_cyc[$];

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got {l4,b4,d4,l1,b1,d1}=%b want %b", tag, obs, exp);
        end
    endtask

    // Reference model. It tracks the sample index of the last toggle and a pending flag.
    // It does not model a counter.
    task automatic mstep(input int h, input bit e, inout mdl_t m);
        bit inwin;
        inwin  = m.busy && ((n - m.last_t) < h);
        m.drop = 1'b0;
        if (!inwin) begin
            if (m.pend) begin
                m.lvl = ~m.lvl; m.last_t = n; m.pend = e; m.busy = 1'b1;
            end else if (e) begin
                m.lvl = ~m.lvl; m.last_t = n; m.busy = 1'b1;
            end else begin
                m.busy = 1'b0;
            end
        end else if (e) begin
            if (m.pend) m.drop = 1'b1;
            else        m.pend = 1'b1;
        end
    endtask

    task automatic mreset();
        m4 = '{lvl: 1'b0, busy: 1'b0, pend: 1'b0, drop: 1'b0, last_t: -1000};
        m1 = '{lvl: 1'b0, busy: 1'b0, pend: 1'b0, drop: 1'b0, last_t: -1000};
    endtask

    task automatic drive(input bit a, input bit b);
        @(negedge clk);
        e4 = a;
        e1 = b;
        n++;
        mstep(4, a, m4);
        mstep(1, b, m1);
        sb.push_back({m4.lvl, m4.busy, m4.drop, m1.lvl, m1.busy, m1.drop});
        sb_cyc.push_back(n);
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle and check that it clears the outputs at once.
    // Hold it for a few cycles with edges driven high; they must be ignored.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async", {l4, b4, d4, l1, b1, d1}, 6'b0);
        e4 = 1'b1;
        e1 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold", {l4, b4, d4, l1, b1, d1}, 6'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        e4    = 1'b0;
        e1    = 1'b0;
        mreset();
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0)
            chk($sformatf("cyc%0d", sb_cyc.pop_front()), {l4, b4, d4, l1, b1, d1}, sb.pop_front());
    end

    initial begin
        mreset();
        #23;
        chk("rst_init", {l4, b4, d4, l1, b1, d1}, 6'b0);
        @(negedge clk);
        reset = 1'b0;

        idle(3);
        drive(1, 0); idle(8);                             // single edge
        drive(1, 0); drive(0, 0); drive(1, 0); idle(10);  // deferred edge
        drive(1, 0); drive(1, 0); drive(1, 0); idle(10);  // drop
        drive(1, 0); idle(3); drive(1, 0); idle(8);       // edge exactly at terminal
        drive(1, 0); drive(1, 0); idle(2); drive(1, 0); idle(10); // re-pend on expiry
        repeat (8) drive(0, 1);                           // HOLD_CYCLES=1 back-to-back
        idle(3);
        drive(1, 1); drive(1, 1);                         // enter PEND, then reset
        do_reset();
        idle(8);
        repeat (300) drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
        idle(8);

        @(posedge clk);
        #2;
        if (sb.size() != 0) chk("sb_drain", 6'(sb.size()), 6'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
